// File: rtl/wb_ram_slave_pkg.sv
// rtl/wb_ram_slave_pkg.sv - shared widths, FSM state type and lane-mask helper for the Wishbone RAM slave
package wb_pkg;

    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;
    localparam int WB_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2,
        HOLD = 2'd3
    } wb_state_e;

    // Expand byte-lane strobes into a per-bit mask over the data word.
    function automatic logic [WB_DAT_W-1:0] wb_lane_mask(input logic [WB_SEL_W-1:0] sel);
        wb_lane_mask = '0;
        for (int i = 0; i < WB_SEL_W; i++) begin
            wb_lane_mask[8*i +: 8] = {8{sel[i]}};
        end
    endfunction

endpackage

// File: rtl/wb_ram_slave_if.sv
// rtl/wb_ram_slave_if.sv - Wishbone bus bundle between uart2wb master and the RAM slave
interface wb_ram_slave_if;
    import wb_pkg::*;

    logic                i_wb_cyc;
    logic [WB_SEL_W-1:0] i_wb_stb;
    logic                i_wb_we;
    logic [31:0]         i_wb_addr;
    logic [WB_DAT_W-1:0] i_wb_dat;
    logic [WB_DAT_W-1:0] o_wb_dat;
    logic                o_wb_ack;
    logic                o_wb_err;

    modport master (
        output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_dat,
        input  o_wb_dat, o_wb_ack, o_wb_err
    );

    modport slave (
        input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_dat,
        output o_wb_dat, o_wb_ack, o_wb_err
    );

endinterface

// File: rtl/wb_ram_array.sv
// rtl/wb_ram_array.sv - DEPTH x 32 word storage with byte-lane writes and a registered read port
module wb_ram_array
    import wb_pkg::*;
#(
    parameter int DEPTH = 65536,
    parameter int IDX_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic [WB_DAT_W-1:0] wr_dat,
    input  logic [WB_SEL_W-1:0] wr_sel,
    input  logic                rd_en,
    input  logic [IDX_W-1:0]    rd_idx,
    output logic [WB_DAT_W-1:0] rd_dat
);

    logic [WB_DAT_W-1:0] mem [DEPTH];
    logic [WB_DAT_W-1:0] wr_mask;
    logic [WB_DAT_W-1:0] rd_dat_d;
    logic [WB_DAT_W-1:0] rd_dat_q;

    // Lane mask and read-register next value; the read register holds between reads.
    always_comb begin
        wr_mask  = wb_lane_mask(wr_sel);
        rd_dat_d = rd_dat_q;
        if (rd_en) begin
            rd_dat_d = mem[rd_idx];
        end
    end

    // Storage is never cleared by reset; only enabled lanes are merged in.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= (mem[wr_idx] & ~wr_mask) | (wr_dat & wr_mask);
        end
    end

    // Read data register, cleared by reset so the bus shows zero until the first read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_dat_q <= '0;
        end else begin
            rd_dat_q <= rd_dat_d;
        end
    end

    assign rd_dat = rd_dat_q;

endmodule

// File: rtl/wb_ram_slave.sv
// rtl/wb_ram_slave.sv - Wishbone RAM slave: capture/wait/ack FSM, range check, optional WB_RAM_SLAVE_ERR_EN error response
module wb_ram_slave
    import wb_pkg::*;
#(
    parameter int DEPTH       = 65536,
    parameter int ADDR_WIDTH  = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic           i_wb_clk,
    input  logic           i_wb_rst,
    wb_ram_slave_if.slave  bus
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [32:0] DEPTH_EXT = 33'(DEPTH);
    localparam logic [WB_CNT_W-1:0] CNT_LOAD =
        (WAIT_STATES > 0) ? WB_CNT_W'(WAIT_STATES - 1) : '0;

    wb_state_e           state_q, state_d;
    logic [WB_CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]         addr_q, addr_d;
    logic                we_q, we_d;
    logic [WB_SEL_W-1:0] stb_q, stb_d;
    logic [WB_DAT_W-1:0] wdat_q, wdat_d;
    logic                ack_q, ack_d;
    logic                rd_zero_q, rd_zero_d;

    logic                to_ack;
    logic                in_range;
    logic                wr_en;
    logic                rd_en;
    logic [ADDR_WIDTH-1:0] req_word;
    logic [IDX_W-1:0]    mem_idx;
    logic [WB_DAT_W-1:0] ram_rd_dat;

    // Next-state logic; request fields are latched only on the capture edge in IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        stb_d   = stb_q;
        wdat_d  = wdat_q;
        to_ack  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.i_wb_cyc) begin
                    addr_d = bus.i_wb_addr;
                    we_d   = bus.i_wb_we;
                    stb_d  = bus.i_wb_stb;
                    wdat_d = bus.i_wb_dat;
                    if (WAIT_STATES == 0) begin
                        state_d = ACK;
                        to_ack  = 1'b1;
                    end else begin
                        cnt_d   = CNT_LOAD;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!bus.i_wb_cyc) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = ACK;
                    to_ack  = 1'b1;
                end else begin
                    cnt_d = cnt_q - WB_CNT_W'(1);
                end
            end
            ACK: begin
                state_d = bus.i_wb_cyc ? HOLD : IDLE;
            end
            HOLD: begin
                if (!bus.i_wb_cyc) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Memory access on the edge entering ACK; *_d already equals the live bus when capture and ACK coincide.
    always_comb begin
        req_word  = addr_d[ADDR_WIDTH-1:0];
        in_range  = ((addr_d >> ADDR_WIDTH) == 32'd0) && (33'(req_word) < DEPTH_EXT);
        mem_idx   = addr_d[IDX_W-1:0];
        wr_en     = to_ack & we_d & in_range & ~i_wb_rst;
        rd_en     = to_ack & ~we_d & in_range & ~i_wb_rst;
        rd_zero_d = rd_zero_q;
`ifdef WB_RAM_SLAVE_ERR_EN
        ack_d     = to_ack & in_range;
`else
        ack_d     = to_ack;
        if (to_ack && !we_d) begin
            rd_zero_d = ~in_range;
        end
`endif
    end

    // FSM and request registers; reset drops any in-flight request and the ack at once.
    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            stb_q     <= '0;
            wdat_q    <= '0;
            ack_q     <= 1'b0;
            rd_zero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            stb_q     <= stb_d;
            wdat_q    <= wdat_d;
            ack_q     <= ack_d;
            rd_zero_q <= rd_zero_d;
        end
    end

`ifdef WB_RAM_SLAVE_ERR_EN
    logic err_q, err_d;

    // Out-of-range accesses answer with err in the ACK cycle instead of ack.
    always_comb begin
        err_d = to_ack & ~in_range;
    end

    // Error strobe register, same timing as ack.
    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.o_wb_err = err_q;
`else
    assign bus.o_wb_err = 1'b0;
`endif

    wb_ram_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk    (i_wb_clk),
        .rst    (i_wb_rst),
        .wr_en  (wr_en),
        .wr_idx (mem_idx),
        .wr_dat (wdat_d),
        .wr_sel (stb_d),
        .rd_en  (rd_en),
        .rd_idx (mem_idx),
        .rd_dat (ram_rd_dat)
    );

    assign bus.o_wb_ack = ack_q;
    assign bus.o_wb_dat = rd_zero_q ? '0 : ram_rd_dat;

endmodule

// File: tb/tb_wb_ram_slave.sv
// tb/tb_wb_ram_slave.sv - randomized self-checking bench for wb_ram_slave with WAIT_STATES 1, 3 and 0
module tb_wb_ram_slave;

    localparam int DEPTH = 1024;
    localparam int NDUT  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [2:0]  m_cyc;
    logic [2:0]  m_we;
    logic [3:0]  m_stb  [NDUT];
    logic [31:0] m_addr [NDUT];
    logic [31:0] m_dat  [NDUT];
    logic [2:0]  s_ack;
    logic [2:0]  s_err;
    logic [31:0] s_dat  [NDUT];

    logic [31:0] mdl_mem [NDUT][DEPTH];
    logic [31:0] mdl_vld [NDUT][DEPTH];
    logic [31:0] mdl_rd  [NDUT];
    logic [31:0] mdl_rv  [NDUT];

    int n_cmp = 0;
    int n_bad = 0;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int WS = (g == 0) ? 1 : ((g == 1) ? 3 : 0);
        wb_ram_slave_if bus ();
        assign bus.i_wb_cyc  = m_cyc[g];
        assign bus.i_wb_we   = m_we[g];
        assign bus.i_wb_stb  = m_stb[g];
        assign bus.i_wb_addr = m_addr[g];
        assign bus.i_wb_dat  = m_dat[g];
        assign s_ack[g]      = bus.o_wb_ack;
        assign s_err[g]      = bus.o_wb_err;
        assign s_dat[g]      = bus.o_wb_dat;
        wb_ram_slave #(
            .DEPTH       (DEPTH),
            .ADDR_WIDTH  (16),
            .WAIT_STATES (WS)
        ) u_dut (
            .i_wb_clk (clk),
            .i_wb_rst (rst),
            .bus      (bus)
        );
    end

    function automatic int ws_of(input int g);
        return (g == 0) ? 1 : ((g == 1) ? 3 : 0);
    endfunction

    function automatic bit addr_ok(input logic [31:0] a);
        return a < 32'(DEPTH);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int g = 0; g < NDUT; g++) begin
            mdl_rd[g] = 32'h0;
            mdl_rv[g] = 32'hFFFF_FFFF;
        end
    endtask

    task automatic txn(input int g, input bit we, input logic [31:0] addr, input logic [31:0] dat,
                       input logic [3:0] stb, input int hold, output logic [31:0] rd);
        int n;
        int acks;
        @(negedge clk);
        m_cyc[g] = 1'b1; m_we[g] = we; m_addr[g] = addr; m_dat[g] = dat; m_stb[g] = stb;
        @(posedge clk); #1;
        n = 1;
        m_addr[g] = $urandom; m_dat[g] = $urandom; m_stb[g] = 4'($urandom);
        while (!s_ack[g] && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("latency", 32'(n), 32'(ws_of(g) + 1));
        check_eq("err", 32'(s_err[g]), 32'h0);
        rd = s_dat[g];
        if (we) begin
            if (addr_ok(addr)) begin
                for (int b = 0; b < 4; b++) begin
                    if (stb[b]) begin
                        mdl_mem[g][addr[9:0]][8*b +: 8] = dat[8*b +: 8];
                        mdl_vld[g][addr[9:0]][8*b +: 8] = 8'hFF;
                    end
                end
            end
        end else if (addr_ok(addr)) begin
            mdl_rd[g] = mdl_mem[g][addr[9:0]];
            mdl_rv[g] = mdl_vld[g][addr[9:0]];
        end else begin
            mdl_rd[g] = 32'h0;
            mdl_rv[g] = 32'hFFFF_FFFF;
        end
        check_eq("rdata", s_dat[g] & mdl_rv[g], mdl_rd[g] & mdl_rv[g]);
        acks = 1;
        repeat (hold) begin
            @(posedge clk); #1;
            if (s_ack[g]) acks++;
        end
        @(negedge clk);
        m_cyc[g] = 1'b0;
        @(posedge clk); #1;
        if (s_ack[g]) acks++;
        check_eq("ack_count", 32'(acks), 32'h1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int acks;
        rst = 1'b1;
        m_cyc = '0;
        m_we  = '0;
        for (int g = 0; g < NDUT; g++) begin
            m_stb[g] = '0; m_addr[g] = '0; m_dat[g] = '0;
            for (int a = 0; a < DEPTH; a++) begin
                mdl_mem[g][a] = '0;
                mdl_vld[g][a] = '0;
            end
        end
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int g = 0; g < NDUT; g++) begin
            check_eq("rst_ack", 32'(s_ack[g]), 32'h0);
            check_eq("rst_err", 32'(s_err[g]), 32'h0);
            check_eq("rst_dat", s_dat[g], 32'h0);
        end

        // write then read, WAIT_STATES=1
        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd);
        txn(0, 1'b0, 32'h10, 32'h0, 4'hF, 0, rd);
        check_eq("plan_rd", rd, 32'hDEADBEEF);

        // byte lanes
        txn(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 0, rd);
        txn(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, rd);
        txn(0, 1'b0, 32'h20, 32'h0, 4'hF, 0, rd);
        check_eq("plan_lanes", rd, 32'h11BB33DD);
        txn(0, 1'b1, 32'h24, 32'h99999999, 4'b0000, 0, rd);

        // hold cyc 5 cycles after ack
        txn(0, 1'b1, 32'h30, 32'h01020304, 4'hF, 5, rd);
        txn(0, 1'b0, 32'h30, 32'h0, 4'hF, 3, rd);
        check_eq("plan_hold", rd, 32'h01020304);

        // abort during WAIT, WAIT_STATES=3
        txn(1, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF, 0, rd);
        @(negedge clk);
        m_cyc[1] = 1'b1; m_we[1] = 1'b1; m_addr[1] = 32'h40; m_dat[1] = 32'h0BADBEEF; m_stb[1] = 4'hF;
        @(posedge clk); #1;
        @(negedge clk);
        m_cyc[1] = 1'b0;
        acks = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (s_ack[1]) acks++;
        end
        check_eq("abort_acks", 32'(acks), 32'h0);
        txn(1, 1'b0, 32'h40, 32'h0, 4'hF, 0, rd);
        check_eq("plan_abort", rd, 32'hCAFEF00D);

        // out of range, DEPTH=1024
        txn(0, 1'b1, 32'h0, 32'h5A5A5A5A, 4'hF, 0, rd);
        txn(0, 1'b1, 32'h400, 32'h12345678, 4'hF, 0, rd);
        txn(0, 1'b1, 32'h10000, 32'h87654321, 4'hF, 0, rd);
        txn(0, 1'b0, 32'h0, 32'h0, 4'hF, 0, rd);
        check_eq("plan_oor_wr", rd, 32'h5A5A5A5A);
        txn(0, 1'b0, 32'h400, 32'h0, 4'hF, 0, rd);
        check_eq("plan_oor_rd", rd, 32'h0);

        // WAIT_STATES=0
        txn(2, 1'b1, 32'h8, 32'hFEEDC0DE, 4'hF, 0, rd);
        txn(2, 1'b0, 32'h8, 32'h0, 4'hF, 0, rd);
        check_eq("plan_ws0", rd, 32'hFEEDC0DE);

        // reset while a write is pending in WAIT: write must be dropped
        @(negedge clk);
        m_cyc[1] = 1'b1; m_we[1] = 1'b1; m_addr[1] = 32'h40; m_dat[1] = 32'h77777777; m_stb[1] = 4'hF;
        @(posedge clk); #3;
        rst = 1'b1;
        m_cyc[1] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        txn(1, 1'b0, 32'h40, 32'h0, 4'hF, 0, rd);
        check_eq("rst_wr_drop", rd, 32'hCAFEF00D);

        // reset inside the ack cycle, WAIT_STATES=0
        @(negedge clk);
        m_cyc[2] = 1'b1; m_we[2] = 1'b0; m_addr[2] = 32'h8; m_stb[2] = 4'hF;
        @(posedge clk); #1;
        check_eq("ack_before_rst", 32'(s_ack[2]), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("ack_async_drop", 32'(s_ack[2]), 32'h0);
        m_cyc[2] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int g = 0; g < NDUT; g++) begin
            check_eq("rst_dat2", s_dat[g], 32'h0);
        end
        txn(2, 1'b0, 32'h8, 32'h0, 4'hF, 0, rd);
        check_eq("post_rst_rd", rd, 32'hFEEDC0DE);

        // randomized traffic against the model
        for (int g = 0; g < NDUT; g++) begin
            for (int i = 0; i < 30; i++) begin
                logic [31:0] a;
                int sel;
                sel = $urandom_range(0, 7);
                if (sel == 0) a = 32'h400 + 32'($urandom_range(0, 15));
                else if (sel == 1) a = 32'h10000 | 32'($urandom_range(0, 15));
                else a = 32'($urandom_range(0, 15));
                txn(g, 1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 2), rd);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
